// File: rtl/ceespu_dmem_arbiter.sv
// ceespu_dmem_arbiter: shares the single-port data block RAM between the CPU
// data path and a DMA/loader requester.
// The CPU has priority. A DMA request denied for MAX_WAIT consecutive cycles is
// forced in, and the CPU is stalled for that cycle.
// Read data returns one cycle after the access and is steered to the port that
// issued the read.
//
// Ports
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_cpu_*               CPU memory request from ceespu_execute (byte address)
//   O_cpu_stall           CPU access not performed this cycle
//   O_cpu_rdata           read data for the CPU (raw RAM output)
//   I_dma_*               DMA request, held with its fields until granted
//   O_dma_gnt             DMA access performed this cycle
//   O_dma_rvalid/rdata    DMA read return
//   O_mem_*, I_mem_rdata  block RAM port
module ceespu_dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_cpu_memE,
    input  logic                  I_cpu_write,
    input  logic [3:0]            I_cpu_memWe,
    input  logic [31:0]           I_cpu_addr,
    input  logic [31:0]           I_cpu_wdata,
    output logic                  O_cpu_stall,
    output logic [31:0]           O_cpu_rdata,
    input  logic                  I_dma_req,
    input  logic [3:0]            I_dma_we,
    input  logic [ADDR_WIDTH-1:0] I_dma_addr,
    input  logic [31:0]           I_dma_wdata,
    output logic                  O_dma_gnt,
    output logic                  O_dma_rvalid,
    output logic [31:0]           O_dma_rdata,
    output logic                  O_mem_en,
    output logic [3:0]            O_mem_we,
    output logic [ADDR_WIDTH-1:0] O_mem_addr,
    output logic [31:0]           O_mem_wdata,
    input  logic [31:0]           I_mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    owner_t     rd_owner;
    owner_t     rd_owner_next;
    logic       force_dma;
    logic       dma_sel;
    logic       cpu_go;

    // Only the word-address bits of the CPU byte address reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{I_cpu_addr[31:ADDR_WIDTH+2], I_cpu_addr[1:0]};

    // State registers: starvation counter and owner of the in-flight read.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wait_cnt <= 8'd0;
            rd_owner <= OWN_NONE;
        end else begin
            wait_cnt <= wait_cnt_next;
            rd_owner <= rd_owner_next;
        end
    end

    // Arbitration, RAM mux and next-state logic.
    always_comb begin
        force_dma     = 1'b0;
        dma_sel       = 1'b0;
        cpu_go        = 1'b0;
        O_dma_gnt     = 1'b0;
        O_cpu_stall   = 1'b0;
        O_mem_en      = 1'b0;
        O_mem_we      = 4'b0000;
        O_mem_addr    = I_cpu_addr[ADDR_WIDTH+1:2];
        O_mem_wdata   = I_cpu_wdata;
        wait_cnt_next = 8'd0;
        rd_owner_next = OWN_NONE;

        force_dma   = I_dma_req && (wait_cnt >= MAX_WAIT_C);
        // Reset masks both ports so nothing reaches the RAM while I_rst is high.
        dma_sel     = !I_rst && I_dma_req && (!I_cpu_memE || force_dma);
        cpu_go      = !I_rst && I_cpu_memE && !dma_sel;
        O_dma_gnt   = dma_sel;
        O_cpu_stall = I_cpu_memE && dma_sel;

        if (dma_sel) begin
            O_mem_en    = 1'b1;
            O_mem_we    = I_dma_we;
            O_mem_addr  = I_dma_addr;
            O_mem_wdata = I_dma_wdata;
        end else begin
            O_mem_en = cpu_go;
            // I_cpu_memWe is don't-care on loads; keep X strobes off the RAM.
            O_mem_we = (cpu_go && I_cpu_write) ? I_cpu_memWe : 4'b0000;
        end

        if (I_dma_req && !dma_sel) begin
            wait_cnt_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end

        if (dma_sel && (I_dma_we == 4'b0000)) begin
            rd_owner_next = OWN_DMA;
        end else if (cpu_go && !I_cpu_write) begin
            rd_owner_next = OWN_CPU;
        end
    end

    // Read return; a return pending across a reset is dropped.
    assign O_dma_rvalid = (rd_owner == OWN_DMA) && !I_rst;
    assign O_dma_rdata  = I_mem_rdata;
    assign O_cpu_rdata  = I_mem_rdata;

endmodule

// File: tb/tb_ceespu_dmem_arbiter.sv
// Directed table-driven bench for ceespu_dmem_arbiter with a byte-write block
// RAM model that has a one-cycle registered read.
module tb_ceespu_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_memE, cpu_write;
    logic [3:0]  cpu_memWe;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic [3:0]  dma_we;
    logic [11:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ceespu_dmem_arbiter #(.ADDR_WIDTH(12), .MAX_WAIT(4)) dut (
        .I_clk(clk), .I_rst(rst),
        .I_cpu_memE(cpu_memE), .I_cpu_write(cpu_write), .I_cpu_memWe(cpu_memWe),
        .I_cpu_addr(cpu_addr), .I_cpu_wdata(cpu_wdata),
        .O_cpu_stall(cpu_stall), .O_cpu_rdata(cpu_rdata),
        .I_dma_req(dma_req), .I_dma_we(dma_we), .I_dma_addr(dma_addr),
        .I_dma_wdata(dma_wdata),
        .O_dma_gnt(dma_gnt), .O_dma_rvalid(dma_rvalid), .O_dma_rdata(dma_rdata),
        .O_mem_en(mem_en), .O_mem_we(mem_we), .O_mem_addr(mem_addr),
        .O_mem_wdata(mem_wdata), .I_mem_rdata(mem_rdata)
    );

    // Block RAM model: byte writes, read-first, data one cycle later.
    logic [31:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[3] = 32'h0000_0011;
        ram[4] = 32'h4444_4444;
        ram[7] = 32'h0000_0077;
        ram[9] = 32'h0000_0099;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        rst, memE, wr;
        logic [3:0]  memWe;
        logic [31:0] addr, wdata;
        logic        dreq;
        logic [3:0]  dwe;
        logic [11:0] daddr;
        logic [31:0] dwdata;
        logic        gnt, stall, en;
        logic [3:0]  we;
        logic [11:0] maddr;
        logic        chk_rv, rv;
        logic        chk_rd;
        logic [31:0] rd;
        logic        chk_crd;
        logic [31:0] crd;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic me, input logic w, input logic [3:0] mwe,
                         input logic [31:0] a, input logic [31:0] wd, input logic dq,
                         input logic [3:0] dw, input logic [11:0] da, input logic [31:0] dd);
        @(negedge clk);
        rst = r; cpu_memE = me; cpu_write = w; cpu_memWe = mwe; cpu_addr = a;
        cpu_wdata = wd; dma_req = dq; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_memE = 1'b0; cpu_write = 1'b0; cpu_memWe = 4'h0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; dma_req = 1'b0; dma_we = 4'h0;
        dma_addr = 12'h0; dma_wdata = 32'h0;

        //            rst memE wr memWe  addr   wdata         dreq dwe   daddr dwdata         gnt stall en we    maddr chkrv rv chkrd rd            chkc crd
        // reset with both ports active
        vq.push_back('{1'b1,1'b1,1'b1,4'hF,32'h10,32'h0,       1'b1,4'hF,12'd5,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd4, 1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b1,1'b1,1'b1,4'hF,32'h10,32'h0,       1'b1,4'hF,12'd5,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd4, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        // idle-CPU DMA write then read of word 5
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,4'hF,12'd5,32'hDEADBEEF,1'b1,1'b0,1'b1,4'hF,12'd5, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,4'h0,12'd5,32'h0,       1'b1,1'b0,1'b1,4'h0,12'd5, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        // CPU store masking: load with X strobes, then a lane-2 store
        vq.push_back('{1'b0,1'b1,1'b0,4'bxxxx,32'h10,32'h0,    1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b1,4'h0,12'd4, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b1,1'b1,4'b0100,32'h10,32'h00AB0000,1'b0,4'h0,12'd0,32'h0,    1'b0,1'b0,1'b1,4'h4,12'd4, 1'b1,1'b0,1'b0,32'h0,       1'b1,32'h44444444});
        vq.push_back('{1'b0,1'b1,1'b0,4'h0,32'h10,32'h0,       1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b1,4'h0,12'd4, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b0,1'b0,32'h0,       1'b1,32'h44AB4444});
        // interleaved CPU read word 3, DMA read word 7
        vq.push_back('{1'b0,1'b1,1'b0,4'h0,32'hC,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b1,4'h0,12'd3, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,4'h0,12'd7,32'h0,       1'b1,1'b0,1'b1,4'h0,12'd7, 1'b1,1'b0,1'b0,32'h0,       1'b1,32'h11});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b1,1'b1,32'h77,      1'b0,32'h0});
        // contention below the guard: CPU wins, then idle CPU lets DMA in
        vq.push_back('{1'b0,1'b1,1'b0,4'h0,32'h0,32'h0,        1'b1,4'h0,12'd9,32'h0,       1'b0,1'b0,1'b1,4'h0,12'd0, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b1,1'b0,4'h0,32'h0,32'h0,        1'b1,4'h0,12'd9,32'h0,       1'b0,1'b0,1'b1,4'h0,12'd0, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,4'h0,12'd9,32'h0,       1'b1,1'b0,1'b1,4'h0,12'd9, 1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0});
        vq.push_back('{1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,4'h0,12'd0,32'h0,       1'b0,1'b0,1'b0,4'h0,12'd0, 1'b1,1'b1,1'b1,32'h99,      1'b0,32'h0});

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].memE, vq[i].wr, vq[i].memWe, vq[i].addr, vq[i].wdata,
                  vq[i].dreq, vq[i].dwe, vq[i].daddr, vq[i].dwdata);
            chk($sformatf("v%0d gnt", i),   32'(dma_gnt),   32'(vq[i].gnt));
            chk($sformatf("v%0d stall", i), 32'(cpu_stall), 32'(vq[i].stall));
            chk($sformatf("v%0d en", i),    32'(mem_en),    32'(vq[i].en));
            chk($sformatf("v%0d we", i),    32'(mem_we),    32'(vq[i].we));
            chk($sformatf("v%0d addr", i),  32'(mem_addr),  32'(vq[i].maddr));
            if (vq[i].chk_rv) chk($sformatf("v%0d rvalid", i), 32'(dma_rvalid), 32'(vq[i].rv));
            if (vq[i].chk_rd) chk($sformatf("v%0d dma_rdata", i), dma_rdata, vq[i].rd);
            if (vq[i].chk_crd) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vq[i].crd);
        end

        // Starvation guard: CPU streams loads, DMA write held; 1-in-5 grants.
        begin
            int grants = 0;
            for (int c = 0; c < 10; c++) begin
                drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 4'hF, 12'd2, 32'hCAFE0000);
                chk($sformatf("starve c%0d gnt", c),   32'(dma_gnt),   32'((c % 5) == 4));
                chk($sformatf("starve c%0d stall", c), 32'(cpu_stall), 32'((c % 5) == 4));
                chk($sformatf("starve c%0d addr", c),  32'(mem_addr),  ((c % 5) == 4) ? 32'd2 : 32'd8);
                chk($sformatf("starve c%0d we", c),    32'(mem_we),    ((c % 5) == 4) ? 32'hF : 32'h0);
                if (dma_gnt) grants++;
            end
            chk("starve grant count", 32'(grants), 32'd2);
        end

        // Reset in the cycle after a granted DMA read drops the return.
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 12'd5, 32'h0);
        chk("rstmid gnt", 32'(dma_gnt), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
        chk("rstmid rvalid in reset", 32'(dma_rvalid), 32'd0);
        chk("rstmid mem_en in reset", 32'(mem_en), 32'd0);
        chk("rstmid stall in reset", 32'(cpu_stall), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
        chk("rstmid rvalid after", 32'(dma_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ceespu_dmem_arbiter.md
# ceespu_dmem_arbiter

Shares the single-port data block RAM between the CPU data path and a secondary DMA/loader requester. The CPU side connects to the memory outputs of ceespu_execute (byte address, enable, byte write strobes, replicated store data). The DMA side uses a request/grant handshake. Policy is CPU priority with a bounded-wait starvation guard. The block stalls the CPU whenever the DMA port is forced in, and routes the one-cycle-latency read data back to the owner of each access.

## Interface
- ADDR_WIDTH, 12, word-address width of the block RAM (memory holds 2^ADDR_WIDTH 32-bit words).
- MAX_WAIT, 4, consecutive denied DMA cycles before the DMA port is forced in; legal range 0..255.

- I_clk  in  1  clock; all state changes on its rising edge.
- I_rst  in  1  synchronous, active-high reset.
- I_cpu_memE  in  1  CPU access enable.
- I_cpu_write  in  1  CPU access is a store; qualifies I_cpu_memWe, which is don't-care when low.
- I_cpu_memWe  in  4  CPU byte write strobes.
- I_cpu_addr  in  32  CPU byte address; bits [ADDR_WIDTH+1:2] are used.
- I_cpu_wdata  in  32  CPU store data, already lane-replicated.
- O_cpu_stall  out  1  CPU access not performed this cycle; the CPU holds its request.
- O_cpu_rdata  out  32  read data for the CPU.
- I_dma_req  in  1  DMA access request; held with its fields until granted.
- I_dma_we  in  4  DMA byte write strobes; 0 means read.
- I_dma_addr  in  ADDR_WIDTH  DMA word address.
- I_dma_wdata  in  32  DMA write data.
- O_dma_gnt  out  1  DMA access performed this cycle.
- O_dma_rvalid  out  1  O_dma_rdata is valid.
- O_dma_rdata  out  32  DMA read data.
- O_mem_en  out  1  block RAM enable.
- O_mem_we  out  4  block RAM byte write enables.
- O_mem_addr  out  ADDR_WIDTH  block RAM word address.
- O_mem_wdata  out  32  block RAM write data.
- I_mem_rdata  in  32  block RAM read data, valid the cycle after an enabled read.

## Operation
- **force** = I_dma_req && (wait_cnt >= MAX_WAIT). wait_cnt is an 8-bit register.
- **Grant rule:**
  - dma_sel = I_dma_req && (!I_cpu_memE || force).
  - O_dma_gnt = dma_sel.
  - O_cpu_stall = I_cpu_memE && dma_sel.
- **Memory mux when dma_sel:**
  - O_mem_en=1, O_mem_we=I_dma_we, O_mem_addr=I_dma_addr, O_mem_wdata=I_dma_wdata.
- **Memory mux otherwise:**
  - O_mem_en=I_cpu_memE.
  - O_mem_we = I_cpu_memE && I_cpu_write ? I_cpu_memWe : 4'b0000. X strobes never reach the RAM.
  - O_mem_addr = I_cpu_addr[ADDR_WIDTH+1:2], O_mem_wdata=I_cpu_wdata.
- **wait_cnt:**
  - Cleared on reset and on any cycle with O_dma_gnt=1 or I_dma_req=0.
  - Otherwise it increments, saturating at 255.
  - A forced grant therefore occurs on the (MAX_WAIT+1)-th consecutive requesting cycle.
  - MAX_WAIT=0 makes the DMA port strict priority.
- **Read return state:** rd_owner register with values NONE, CPU, DMA.
  - Loaded each cycle: DMA if dma_sel && I_dma_we==0; CPU if CPU access performed && !I_cpu_write; else NONE.
  - O_dma_rvalid = (rd_owner==DMA); O_dma_rdata = I_mem_rdata.
  - O_cpu_rdata = I_mem_rdata, unconditionally. The CPU pipeline samples it one cycle after its access, as with a bare block RAM.
- **Reset:**
  - While I_rst=1, O_dma_gnt, O_cpu_stall, O_mem_en and O_mem_we are forced to 0.
  - wait_cnt=0, rd_owner=NONE, so O_dma_rvalid=0 in the cycle after reset.
  - Reset mid-read discards the pending return; no rvalid is produced for it.

## Timing
- Grant and stall are combinational, same cycle as the request. No bubble between back-to-back accesses from either port.
- Read latency: data valid exactly 1 cycle after the granted access. Back-to-back reads give one rvalid per cycle.
- DMA worst-case wait with continuous CPU traffic: MAX_WAIT cycles denied, granted on the next cycle.
- Each forced grant costs the CPU exactly one stall cycle; wait_cnt restarts from 0.
- Simultaneous events:
  - CPU idle and DMA requesting: DMA granted, no stall.
  - Both requesting and not forced: CPU wins, wait_cnt increments.
- Registered state: wait_cnt, rd_owner. All other outputs are combinational.

## Test plan
- **Reset:** assert I_rst 2 cycles with I_dma_req=1 and I_cpu_memE=1 -> gnt, stall, mem_en, mem_we all 0; rvalid=0 in the first cycle after release.
- **Idle-CPU DMA:** DMA write 0xDEADBEEF, we=4'hF to word 5, then DMA read of word 5 -> gnt both cycles; rvalid=1 and rdata=0xDEADBEEF one cycle after the read; no stall.
- **Starvation guard:** MAX_WAIT=4, CPU memE held high, DMA req held -> gnt=0 for 4 cycles, gnt=1 with stall=1 on cycle 5, counter restarts; repeated pattern gives a 1-in-5 DMA grant rate.
- **CPU store masking:** I_cpu_write=0 with memWe=4'bxxxx, addr 0x10 -> O_mem_we=0, O_mem_addr=4; I_cpu_write=1, memWe=4'b0100 -> O_mem_we=4'b0100.
- **Interleaved reads:** CPU read of word 3 (data 0x11) followed immediately by a DMA read of word 7 (data 0x77), CPU idle on cycle 2 -> cycle 2: CPU sees 0x11 and rvalid=0; cycle 3: rvalid=1 with 0x77.
- **Reset mid-read:** DMA read granted, I_rst asserted in the next cycle -> O_dma_rvalid stays 0.
